// File: rtl/led_matrix_pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_pkg : shared types, defaults and helpers for the LED scan driver |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package led_pkg;

    localparam int DEF_ROWS     = 4;
    localparam int DEF_COLS     = 4;
    localparam int DEF_BITS     = 4;
    localparam int DEF_PRESCALE = 32;
    localparam int DEF_BLANK    = 2;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

    // Width needed to index n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_matrix_pwm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_matrix_pwm_if : frame-store write/swap port and matrix drive pins |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface led_matrix_pwm_if
    import led_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int BITS = DEF_BITS
);
    localparam int AW = idx_w(ROWS * COLS);

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [BITS-1:0] wr_data;
    logic            swap_req;
    logic            swap_ack;
    logic            frame_start;
    logic [ROWS-1:0] row_n;
    logic [COLS-1:0] col_oe;

    modport master (
        output wr_en, wr_addr, wr_data, swap_req,
        input  swap_ack, frame_start, row_n, col_oe
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, swap_req,
        output swap_ack, frame_start, row_n, col_oe
    );
endinterface
`default_nettype wire

// File: rtl/led_matrix_pwm_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_tick_gen : one-cycle strobe every PRESCALE clocks                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module led_tick_gen
    import led_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    localparam int CW = idx_w(PRESCALE);

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == CW'(PRESCALE - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
            tick_q <= 1'b0;
        end
    end

    assign tick_o = tick_q;
endmodule
`default_nettype wire

// File: rtl/led_matrix_pwm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_matrix_pwm : double-buffered row-scan PWM driver for a LED matrix |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module led_matrix_pwm
    import led_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int BITS     = DEF_BITS,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int BLANK    = DEF_BLANK
) (
    input  logic            clk,
    input  logic            rst,
    led_matrix_pwm_if.slave bus
);
    localparam int N        = ROWS * COLS;
    localparam int RW       = idx_w(ROWS);
    localparam int ON_TICKS = (1 << BITS) - 1;
    localparam int PMAX     = (ON_TICKS > BLANK) ? ON_TICKS : BLANK;
    localparam int PW       = idx_w(PMAX);

    generate
        if (BLANK < 1 || PRESCALE < 1 || ROWS < 1 || COLS < 1 || BITS < 1) begin : g_bad_params
            $error("led_matrix_pwm: ROWS, COLS, BITS, PRESCALE and BLANK must all be >= 1");
        end
    endgenerate

    logic tick;

    led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    scan_state_e     state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            front_q, pending_q, started_q;
    logic            frame_start_q, swap_ack_q;
    logic [ROWS-1:0] row_n_q, row_n_d;
    logic [COLS-1:0] col_oe_q, col_oe_d;
    logic [BITS-1:0] mem_q    [2][N];
    logic [BITS-1:0] rowbuf_q [COLS];
    logic            latch, boundary, swap;

    // Phase counts blanking ticks in BLANK and PWM ticks in ON.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        phase_d  = phase_q;
        latch    = 1'b0;
        boundary = 1'b0;
        if (tick) begin
            case (state_q)
                ST_BLANK: begin
                    if (phase_q == PW'(BLANK - 1)) begin
                        state_d = ST_ON;
                        phase_d = '0;
                        latch   = 1'b1;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
                ST_ON: begin
                    if (phase_q == PW'(ON_TICKS - 1)) begin
                        state_d = ST_BLANK;
                        phase_d = '0;
                        if (row_q == RW'(ROWS - 1)) begin
                            row_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end
        swap = boundary & (pending_q | bus.swap_req);
    end

    always_comb begin
        row_n_d  = '1;
        col_oe_d = '0;
        if (state_q == ST_ON) begin
            row_n_d[row_q] = 1'b0;
            for (int c = 0; c < COLS; c++) begin
                col_oe_d[c] = (32'(phase_q) < 32'(rowbuf_q[c]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BLANK;
            row_q         <= '0;
            phase_q       <= '0;
            front_q       <= 1'b0;
            pending_q     <= 1'b0;
            started_q     <= 1'b0;
            frame_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            row_n_q       <= '1;
            col_oe_q      <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            phase_q       <= phase_d;
            started_q     <= 1'b1;
            frame_start_q <= ~started_q | boundary;
            swap_ack_q    <= swap;
            row_n_q       <= row_n_d;
            col_oe_q      <= col_oe_d;
            if (swap) begin
                front_q   <= ~front_q;
                pending_q <= 1'b0;
            end else if (bus.swap_req) begin
                pending_q <= 1'b1;
            end
        end
    end

    // A write in the boundary cycle still sees the old front, so it lands in the bank about to be shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                rowbuf_q[c] <= '0;
            end
        end else begin
            if (bus.wr_en && (32'(bus.wr_addr) < 32'(N))) begin
                mem_q[~front_q][bus.wr_addr] <= bus.wr_data;
            end
            if (latch) begin
                for (int c = 0; c < COLS; c++) begin
                    rowbuf_q[c] <= mem_q[front_q][int'(row_q) * COLS + c];
                end
            end
        end
    end

    assign bus.row_n       = row_n_q;
    assign bus.col_oe      = col_oe_q;
    assign bus.frame_start = frame_start_q;
    assign bus.swap_ack    = swap_ack_q;
endmodule
`default_nettype wire

// File: tb/tb_led_matrix_pwm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_matrix_pwm : vector table, corner sequences, random vs model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_led_matrix_pwm;
    import led_pkg::*;

    localparam int ROWS      = DEF_ROWS;
    localparam int COLS      = DEF_COLS;
    localparam int BITS      = DEF_BITS;
    localparam int PRESCALE  = DEF_PRESCALE;
    localparam int BLANK     = DEF_BLANK;
    localparam int N         = ROWS * COLS;
    localparam int AW        = idx_w(N);
    localparam int ON_TICKS  = (1 << BITS) - 1;
    localparam int SLOT      = (ON_TICKS + BLANK) * PRESCALE;
    localparam int FRAME     = ROWS * SLOT;
    localparam int BLANK_CYC = BLANK * PRESCALE;

    typedef struct {
        int              t;
        logic [ROWS-1:0] rn;
        logic [COLS-1:0] oe;
        logic            fs;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_matrix_pwm_if #(.ROWS(ROWS), .COLS(COLS), .BITS(BITS)) bus ();

    led_matrix_pwm #(
        .ROWS(ROWS), .COLS(COLS), .BITS(BITS), .PRESCALE(PRESCALE), .BLANK(BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    tests = 0;
    int    fails = 0;
    int    cyc_err = 0;
    string first_err = "";

    // Reference: time since reset release, bank contents, and a snapshot of the front bank per frame.
    int              m_t = -1;
    logic [BITS-1:0] m_front [N];
    logic [BITS-1:0] m_back  [N];
    logic [BITS-1:0] m_cur   [N];
    logic [BITS-1:0] m_prev  [N];
    logic            m_pend = 1'b0;
    logic            m_ack  = 1'b0;

    task automatic model_edge(input logic r, input logic we, input int addr, input int data, input logic sreq);
        logic [BITS-1:0] tmp;
        if (r) begin
            m_t = -1; m_pend = 1'b0; m_ack = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_front[i] = '0; m_back[i] = '0; m_cur[i] = '0; m_prev[i] = '0;
            end
            return;
        end
        m_t++;
        m_ack = 1'b0;
        if (we && addr < N) m_back[addr] = data[BITS-1:0];
        if (m_t > 0 && m_t % FRAME == 0) begin
            for (int i = 0; i < N; i++) m_prev[i] = m_cur[i];
            if (m_pend || sreq) begin
                for (int i = 0; i < N; i++) begin
                    tmp = m_front[i]; m_front[i] = m_back[i]; m_back[i] = tmp;
                end
                m_pend = 1'b0;
                m_ack  = 1'b1;
            end
        end else if (sreq) begin
            m_pend = 1'b1;
        end
        if (m_t % FRAME == 0) begin
            for (int i = 0; i < N; i++) m_cur[i] = m_front[i];
        end
    endtask

    task automatic expect_out(output logic [ROWS-1:0] rn, output logic [COLS-1:0] oe,
                              output logic fs, output logic ack);
        int s, f, r, o, p;
        rn = '1; oe = '0; fs = 1'b0; ack = 1'b0;
        if (m_t < 0) return;
        fs  = (m_t % FRAME == 0);
        ack = m_ack;
        s = m_t - 1;
        if (s < 0) return;
        f = s % FRAME;
        r = f / SLOT;
        o = f % SLOT;
        if (o < BLANK_CYC) return;
        p = (o - BLANK_CYC) / PRESCALE;
        rn[r] = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (fs) oe[c] = (p < int'(m_prev[r * COLS + c]));
            else    oe[c] = (p < int'(m_cur[r * COLS + c]));
        end
    endtask

    task automatic cycle(input logic we, input int addr, input int data, input logic sreq);
        logic [ROWS-1:0] ern;
        logic [COLS-1:0] eoe;
        logic            efs, eack, r;
        bus.wr_en    = we;
        bus.wr_addr  = AW'(addr);
        bus.wr_data  = BITS'(data);
        bus.swap_req = sreq;
        r = rst;
        @(posedge clk);
        model_edge(r, we, addr, data, sreq);
        #1;
        expect_out(ern, eoe, efs, eack);
        if ({bus.row_n, bus.col_oe, bus.frame_start, bus.swap_ack} !== {ern, eoe, efs, eack}) begin
            cyc_err++;
            if (cyc_err == 1)
                first_err = $sformatf("t=%0d row_n=%b want %b col_oe=%b want %b fs=%b want %b ack=%b want %b",
                                      m_t, bus.row_n, ern, bus.col_oe, eoe, bus.frame_start, efs, bus.swap_ack, eack);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 1'b0);
    endtask

    task automatic run_to(input int target);
        while (m_t < target) idle();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    task automatic window(input string name);
        tests++;
        if (cyc_err != 0) begin
            fails++;
            $display("FAIL %s: %0d cycles differ from model, expected 0; first: %s", name, cyc_err, first_err);
        end
        cyc_err = 0;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[$];
        int   nfs, noe, nack, base, k;

        // Display probes for the frame after a swap with addr0=1, addr5=15, addr10=7.
        tab.push_back('{0,    4'b0111, 4'b0000, 1'b1});
        tab.push_back('{1,    4'b1111, 4'b0000, 1'b0});
        tab.push_back('{64,   4'b1111, 4'b0000, 1'b0});
        tab.push_back('{65,   4'b1110, 4'b0001, 1'b0});
        tab.push_back('{96,   4'b1110, 4'b0001, 1'b0});
        tab.push_back('{97,   4'b1110, 4'b0000, 1'b0});
        tab.push_back('{544,  4'b1110, 4'b0000, 1'b0});
        tab.push_back('{545,  4'b1111, 4'b0000, 1'b0});
        tab.push_back('{609,  4'b1101, 4'b0010, 1'b0});
        tab.push_back('{1088, 4'b1101, 4'b0010, 1'b0});
        tab.push_back('{1089, 4'b1111, 4'b0000, 1'b0});
        tab.push_back('{1153, 4'b1011, 4'b0100, 1'b0});
        tab.push_back('{1376, 4'b1011, 4'b0100, 1'b0});
        tab.push_back('{1377, 4'b1011, 4'b0000, 1'b0});
        tab.push_back('{1697, 4'b0111, 4'b0000, 1'b0});
        tab.push_back('{2176, 4'b0111, 4'b0000, 1'b1});

        rst = 1'b1;
        repeat (3) idle();
        check("reset row_n", 32'(bus.row_n), 32'hF);
        check("reset col_oe", 32'(bus.col_oe), 32'h0);
        check("reset frame_start", 32'(bus.frame_start), 32'h0);
        check("reset swap_ack", 32'(bus.swap_ack), 32'h0);

        rst = 1'b0;
        idle();
        check("frame_start after release", 32'(bus.frame_start), 32'h1);
        nfs = 0; noe = 0;
        while (m_t < FRAME - 1) begin
            idle();
            nfs += int'(bus.frame_start);
            noe += int'(bus.col_oe != '0);
        end
        check("no frame_start mid frame", 32'(nfs), 32'h0);
        check("col_oe dark when idle", 32'(noe), 32'h0);
        idle();
        check("frame_start period", 32'(bus.frame_start), 32'h1);
        window("idle frame");

        cycle(1'b1, 0, 1, 1'b0);
        cycle(1'b1, 5, 15, 1'b0);
        cycle(1'b1, 10, 7, 1'b0);
        cycle(1'b0, 0, 0, 1'b1);
        run_to(2 * FRAME);
        check("swap_ack with frame_start", 32'({bus.swap_ack, bus.frame_start}), 32'h3);
        base = 2 * FRAME;
        for (int i = 0; i < tab.size(); i++) begin
            run_to(base + tab[i].t);
            check($sformatf("vec%0d row_n", i), 32'(bus.row_n), 32'(tab[i].rn));
            check($sformatf("vec%0d col_oe", i), 32'(bus.col_oe), 32'(tab[i].oe));
            check($sformatf("vec%0d frame_start", i), 32'(bus.frame_start), 32'(tab[i].fs));
        end
        window("swap frame");

        cycle(1'b1, 3, 7, 1'b0);
        noe = 0;
        while (m_t < 6 * FRAME) begin
            idle();
            noe += int'(bus.col_oe[3]);
        end
        check("unswapped write invisible", 32'(noe), 32'h0);
        window("no-swap frames");

        run_to(7 * FRAME - 1);
        cycle(1'b0, 0, 0, 1'b1);
        check("ack on boundary request", 32'(bus.swap_ack), 32'h1);
        run_to(7 * FRAME + BLANK_CYC + 1);
        check("new front row0", 32'(bus.col_oe), 32'h8);

        run_to(8 * FRAME);
        check("no spurious ack", 32'(bus.swap_ack), 32'h0);
        cycle(1'b0, 0, 0, 1'b1);
        nack = 0;
        while (m_t < 9 * FRAME - 1) begin
            idle();
            nack += int'(bus.swap_ack);
        end
        check("late request not early", 32'(nack), 32'h0);
        idle();
        check("late request deferred ack", 32'(bus.swap_ack), 32'h1);

        run_to(9 * FRAME + 100);
        cycle(1'b0, 0, 0, 1'b1);
        run_to(9 * FRAME + 1000);
        cycle(1'b0, 0, 0, 1'b1);
        nack = 0;
        while (m_t < 11 * FRAME) begin
            idle();
            nack += int'(bus.swap_ack);
        end
        check("two requests one ack", 32'(nack), 32'h1);
        window("swap timing");

        k = 0;
        while (m_t < 15 * FRAME) begin
            cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, N - 1)),
                  int'($urandom_range(0, ON_TICKS)), ($urandom_range(0, 599) == 0));
            if (m_t % FRAME == 0) begin
                window($sformatf("random frame %0d", k));
                k++;
            end
        end

        run_to(15 * FRAME + 2 * SLOT + BLANK_CYC + 100);
        check("row2 ON before reset", 32'(bus.row_n), 32'hB);
        rst = 1'b1;
        idle();
        check("mid reset row_n", 32'(bus.row_n), 32'hF);
        check("mid reset col_oe", 32'(bus.col_oe), 32'h0);
        idle();
        rst = 1'b0;
        idle();
        check("frame_start after re-release", 32'(bus.frame_start), 32'h1);
        run_to(BLANK_CYC + 1);
        check("scan restarts at row0", 32'(bus.row_n), 32'hE);
        cycle(1'b0, 0, 0, 1'b1);
        noe = 0;
        while (m_t < 2 * FRAME) begin
            idle();
            noe += int'(bus.col_oe != '0);
        end
        check("banks cleared by reset", 32'(noe), 32'h0);
        window("after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/led_matrix_pwm.md
# led_matrix_pwm

Parametrised scan driver for a ROWS×COLS LED matrix with per-LED BITS-bit brightness. It holds a double-buffered frame store, with the back bank writable at any time and the front bank displayed. Rows are scanned one at a time. Within each row slot, every column is driven by PWM against its stored level, and a blanking interval separates rows. It sits between the user logic (waveform/PDM sources) and the SB_IO tri-state pads of the matrix: `row_n` drives the anodes and `col_oe` drives the cathode output enables.

## Interface
- ROWS, 4, number of matrix rows (≥1)
- COLS, 4, number of matrix columns (≥1)
- BITS, 4, brightness resolution; levels 0..2^BITS-1 (≥1)
- PRESCALE, 32, clk cycles per PWM tick (≥1)
- BLANK, 2, blanking ticks per row slot (≥1)
- AW, derived = $clog2(ROWS*COLS), write address width
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write strobe, back bank
- wr_addr  in  AW  LED index = row*COLS + col
- wr_data  in  BITS  brightness level
- swap_req  in  1  request bank swap (single-cycle pulse or level)
- swap_ack  out  1  one-cycle pulse: swap performed
- frame_start  out  1  one-cycle pulse: first cycle of row 0 slot
- row_n  out  ROWS  active-low row select; one-hot-low during ON, all ones otherwise
- col_oe  out  COLS  active-high column enable; all zero outside ON

## Operation
- Reset: both banks are cleared to 0 and the front bank is bank 0. Row = 0, state BLANK, tick/phase counters = 0, pending = 0. Outputs: row_n = all ones, col_oe = 0, swap_ack = 0, frame_start = 0.
- Tick generator: strobes once every PRESCALE clk cycles. State counters advance only on ticks.
- FSM per row slot:
  - BLANK (BLANK ticks): row_n all ones, col_oe 0. On the last BLANK tick, the front-bank levels for the current row are latched into a row buffer.
  - ON (2^BITS-1 ticks, phase p = 0..2^BITS-2): row_n[row] = 0; col_oe[c] = (p < level[c]).
  - After the last ON tick: row ← row+1, wrapping ROWS-1 → 0; state → BLANK.
- Levels: level 0 means never on; level 2^BITS-1 means on for the whole ON period.
- Writes: wr_en stores wr_data in the back bank at wr_addr. If wr_addr ≥ ROWS*COLS, the write is ignored. Writes never touch the front bank.
- Swap:
  - swap_req sets pending.
  - At the frame boundary (the clk cycle of the last ON tick of row ROWS-1), if pending or swap_req is set, the banks flip and pending clears.
  - A request at the boundary cycle is honoured in that same boundary.
  - A request in the cycle after the boundary waits for the next frame.
  - A write in the boundary cycle lands in the pre-flip back bank, so it is displayed in the new frame.
- frame_start: pulses in the first cycle of row 0 BLANK, including the first cycle after reset release.
- swap_ack: pulses in the same cycle as frame_start when a swap occurred.
- Reset mid-operation: rst overrides everything, and the outputs go dark on the next clk edge.

## Timing
- All outputs are registered and change only on clk edges. row_n and col_oe update one cycle after the tick strobe.
- Row slot length = (2^BITS-1+BLANK)·PRESCALE cycles. Defaults: 17·32 = 544 cycles per row, 2176 cycles per frame.
- ON width for level L = L·PRESCALE cycles, contiguous from the start of ON.
- Write-to-display latency: display happens at the first boundary after both the write and a swap request.
- No combinational path from any input to any output.

## Structure
- Shared package `led_pkg`:
  - FSM state enum {BLANK, ON}.
  - Helper function for index width.
  - Default parameter constants.
- Sub-module `led_tick_gen` (PRESCALE counter → tick strobe, synchronous reset).
- Frame store: flip-flop array 2×ROWS×COLS×BITS. There is no BRAM requirement at default sizes.
- Elaboration-time check: BLANK ≥ 1, PRESCALE ≥ 1.

## Test plan
Defaults are used unless noted.
- Reset release, no writes: frame_start pulses in cycle 1 and then every 2176 cycles. row_n stays 4'b1111 except the one-hot-low row during ON; col_oe = 0 throughout.
- Write addr 5 = 15, pulse swap_req: swap_ack appears together with the next frame_start. In the row 1 ON period, row_n = 4'b1101 and col_oe = 4'b0010 for exactly 480 cycles.
- Write addr 0 = 1, then swap: col_oe[0] is high exactly 32 cycles per frame, starting 64 cycles after frame_start (plus 1-cycle register delay).
- Write addr 3 = 7 without swap: the display is unchanged for ≥3 frames. A write to addr 16 has no effect after a swap.
- swap_req in the boundary cycle: the swap happens in that frame. swap_req one cycle later: the swap is deferred by exactly 2176 cycles. Two requests within a frame produce one ack.
- Assert rst during row 2 ON: next cycle row_n = 4'b1111, col_oe = 0, and banks read 0. After release, frame_start occurs in cycle 1 and scanning restarts at row 0.
